dwt_coeff_collector: RTL and testbench

- Downstream of the low/high-pass convolution pair (MODE=1 lo, MODE=0 hi) that run in lockstep on the same decimated sample stream.
- Captures each kept (write-enabled) approximation and detail coefficient into two on-chip banks.
- Counts a frame, raises done, and exposes a synchronous read port so the AIRISC core can fetch coefficients for HSS feature extraction.

---
 rtl/dwt_pkg.sv | 15 +
 rtl/dwt_coeff_bank.sv | 35 +++
 rtl/dwt_coeff_collector.sv | 151 +++++++++++++++
 tb/tb_dwt_coeff_collector.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
// Shared definitions for the DWT coefficient path: FSM state encoding,
// default coefficient width and the 1.14 fixed-point format constant used
// by the convolution stages upstream of the collector.
package dwt_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int FRAC_BITS  = 14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/dwt_coeff_bank.sv
// Simple dual-port coefficient bank: one write port, one registered read
// port, read-first on address collision. The array carries no reset so it
// maps onto block RAM; only the read output register is cleared.
module dwt_coeff_bank #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Write port: array has no reset so it stays a plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; old contents are returned when the same address is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dwt_coeff_collector.sv
// DWT coefficient collector: captures paired approximation (lo) and detail
// (hi) coefficients from the convolution stages into two banks, counts one
// frame, signals done, and offers a 1-cycle-latency read port to the CPU.
// Optional feature macro: DWT_DETAIL_ENERGY_EN adds an 'energy' output that
// accumulates the squared detail coefficients of the frame.
module dwt_coeff_collector
    import dwt_pkg::*;
#(
    parameter int N_COEFF = 512,
    parameter int AW      = 9,
    parameter int DW      = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          ack,
    input  logic [DW-1:0] lo_data,
    input  logic          lo_we,
    input  logic [DW-1:0] hi_data,
    input  logic          hi_we,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_sel,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic          sync_err,
`ifdef DWT_DETAIL_ENERGY_EN
    output logic [2*DW+AW:0] energy,
`endif
    output logic          overrun
);

    localparam logic [AW:0] CNT_LAST = (AW+1)'(N_COEFF - 1);

    state_t        state;
    logic          wr;
    logic          sel_q;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;

    // A pair is stored only while collecting and only when both stages agree.
    assign wr = (state == ST_COLLECT) && lo_we && hi_we;

    dwt_coeff_bank #(.AW(AW), .DW(DW)) u_bank_a (
        .clk   (CLK),
        .rst_n (RST),
        .we    (wr),
        .waddr (count[AW-1:0]),
        .wdata (lo_data),
        .raddr (rd_addr),
        .rdata (rd_a)
    );

    dwt_coeff_bank #(.AW(AW), .DW(DW)) u_bank_b (
        .clk   (CLK),
        .rst_n (RST),
        .we    (wr),
        .waddr (count[AW-1:0]),
        .wdata (hi_data),
        .raddr (rd_addr),
        .rdata (rd_b)
    );

    // Bank select is registered alongside the RAM read so the mux lines up.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= rd_sel;
        end
    end

    assign rd_data = sel_q ? rd_b : rd_a;

    // Frame control FSM with registered, state-decoded busy/done and sticky flags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            sync_err <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_COLLECT;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        count    <= '0;
                        sync_err <= 1'b0;
                        overrun  <= 1'b0;
                    end else if (lo_we || hi_we) begin
                        overrun <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (lo_we && hi_we) begin
                        count <= count + 1'b1;
                        if (count == CNT_LAST) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else if (lo_we ^ hi_we) begin
                        sync_err <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // ack takes priority; a coincident start is dropped.
                    if (ack) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                    if (lo_we || hi_we) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DWT_DETAIL_ENERGY_EN
    logic signed [DW-1:0]   hi_s;
    logic signed [2*DW-1:0] sq;

    assign hi_s = hi_data;
    assign sq   = hi_s * hi_s;

    // Square is folded into the accumulator on the write edge itself, so the
    // last coefficient is included on the same edge that raises done.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            energy <= '0;
        end else if (state == ST_IDLE && start) begin
            energy <= '0;
        end else if (wr) begin
            energy <= energy + {{(AW+1){1'b0}}, sq};
        end
    end
`endif

endmodule

// File: tb/tb_dwt_coeff_collector.sv
// Self-checking bench for dwt_coeff_collector (N_COEFF overridden to 8).
module tb_dwt_coeff_collector;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int NC = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic          ack = 1'b0;
    logic [DW-1:0] lo_data = '0;
    logic          lo_we = 1'b0;
    logic [DW-1:0] hi_data = '0;
    logic          hi_we = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_sel = 1'b0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          sync_err;
    logic          overrun;
`ifdef DWT_DETAIL_ENERGY_EN
    logic [2*DW+AW:0] energy;
    longint           exp_energy;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] m_a [NC];
    logic [DW-1:0] m_b [NC];
    bit            known [NC];
    int            m_cnt;
    bit            m_collect;
    logic [DW-1:0] rd_q [$];

    dwt_coeff_collector #(.N_COEFF(NC), .AW(AW), .DW(DW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .ack      (ack),
        .lo_data  (lo_data),
        .lo_we    (lo_we),
        .hi_data  (hi_data),
        .hi_we    (hi_we),
        .rd_addr  (rd_addr),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .sync_err (sync_err),
`ifdef DWT_DETAIL_ENERGY_EN
        .energy   (energy),
`endif
        .overrun  (overrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One cycle of stimulus: optional write pair plus a read of (rs, ra).
    // The expected read value (pre-write contents) is queued before the edge.
    task automatic drive(input bit lw, input bit hw, input logic [DW-1:0] lo,
                         input logic [DW-1:0] hi, input int ra, input bit rs);
        bit do_chk;
        lo_we   = lw;
        hi_we   = hw;
        lo_data = lo;
        hi_data = hi;
        rd_addr = AW'(ra);
        rd_sel  = rs;
        do_chk  = known[ra];
        if (do_chk) rd_q.push_back(rs ? m_b[ra] : m_a[ra]);
        tick();
        if (do_chk) check("rd_data", rd_data, rd_q.pop_front());
        if (m_collect && lw && hw) begin
            m_a[m_cnt]   = lo;
            m_b[m_cnt]   = hi;
            known[m_cnt] = 1'b1;
`ifdef DWT_DETAIL_ENERGY_EN
            exp_energy += $signed(hi) * $signed(hi);
`endif
            m_cnt++;
            if (m_cnt == NC) m_collect = 1'b0;
        end
        lo_we = 1'b0;
        hi_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_collect = 1'b1;
        m_cnt = 0;
`ifdef DWT_DETAIL_ENERGY_EN
        exp_energy = 0;
`endif
    endtask

    initial begin
        logic [DW-1:0] v;
        logic [DW-1:0] lo_v;
        for (int i = 0; i < NC; i++) known[i] = 1'b0;
        m_cnt = 0;
        m_collect = 1'b0;

        // Reset state, before any clock edge
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_overrun", overrun, 0);
        tick();
        RST = 1'b1;
        tick();

        // Frame 1: lo=k, hi=-k, with a lone lo_we before the 4th pair
        do_start();
        check("f1_busy", busy, 1);
        check("f1_count0", count, 0);
        for (int k = 1; k <= NC; k++) begin
            if (k == 4) begin
                drive(1'b1, 1'b0, 16'h1234, 16'h0000, 0, 1'b0);
                check("sync_err", sync_err, 1);
                check("sync_count", count, 3);
            end
            v = DW'(-k);
            drive(1'b1, 1'b1, DW'(k), v, k - 1, 1'(k & 1));
            check("f1_count", count, 64'(k));
            check("f1_busy_k", busy, (k < NC) ? 1 : 0);
            check("f1_done_k", done, (k == NC) ? 1 : 0);
        end
`ifdef DWT_DETAIL_ENERGY_EN
        check("f1_energy", energy, 64'(exp_energy));
`endif
        for (int i = 0; i < NC; i++) drive(1'b0, 1'b0, '0, '0, i, 1'b0);
        for (int i = 0; i < NC; i++) drive(1'b0, 1'b0, '0, '0, i, 1'b1);
        check("b7_value", m_b[7], 16'hFFF8);

        // Overrun in DONE: banks untouched
        drive(1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 0, 1'b0);
        check("ovr_flag", overrun, 1);
        check("ovr_done", done, 1);
        check("ovr_count", count, NC);
        drive(1'b0, 1'b0, '0, '0, 0, 1'b1);
        check("ovr_sync_sticky", sync_err, 1);
`ifdef DWT_DETAIL_ENERGY_EN
        check("ovr_energy_hold", energy, 64'(exp_energy));
`endif

        // start and ack together in DONE: ack wins
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        check("sa_done", done, 0);
        check("sa_busy", busy, 0);
        tick();
        check("sa_busy2", busy, 0);
        check("sa_ovr_kept", overrun, 1);

        // Frame 2: start clears flags, then async reset mid-frame
        do_start();
        check("f2_ovr_clr", overrun, 0);
        check("f2_sync_clr", sync_err, 0);
        check("f2_count0", count, 0);
        check("f2_busy", busy, 1);
        for (int k = 1; k <= 5; k++) begin
            v = DW'(-(10 + k));
            drive(1'b1, 1'b1, DW'(10 + k), v, k - 1, 1'(k & 1));
        end
        check("f2_count5", count, 5);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_count", count, 0);
        check("arst_done", done, 0);
        #1;
        RST = 1'b1;
        m_collect = 1'b0;
        m_cnt = 0;

        // Frame 3: detail pattern 3, -4, 0x4000, then zeros
        do_start();
        check("f3_busy", busy, 1);
        for (int k = 1; k <= NC; k++) begin
            case (k)
                1: v = 16'd3;
                2: v = 16'hFFFC;
                3: v = 16'h4000;
                default: v = 16'd0;
            endcase
            lo_v = DW'(20 + k);
            drive(1'b1, 1'b1, lo_v, v, k - 1, 1'(k & 1));
        end
        check("f3_done", done, 1);
        check("f3_count", count, NC);
        check("f3_busy_end", busy, 0);
`ifdef DWT_DETAIL_ENERGY_EN
        check("f3_energy", energy, 64'h10000019);
`endif
        for (int i = 0; i < NC; i++) drive(1'b0, 1'b0, '0, '0, i, 1'b0);
        for (int i = 0; i < NC; i++) drive(1'b0, 1'b0, '0, '0, i, 1'b1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("f3_ack_done", done, 0);
        check("f3_ack_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
